// File: rtl/uart_prog_loader.sv
// uart_prog_loader: assembles a UART byte stream into memory word writes.
//
// Bytes received while load_en is high are packed into WORD_WIDTH-bit words
// (first byte MSB when BIG_ENDIAN=1, LSB otherwise). Each complete word is
// written to consecutive addresses starting at BASE_ADDR. Every load_en rising
// edge starts a new session. A partial word is dropped after TIMEOUT_CYCLES
// idle cycles. Bytes that arrive after MAX_WORDS words are ignored.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load_en         session level (rising edge starts a session)
//   rx_valid/rx_byte  received byte strobe and data
//   mem_we/mem_addr/mem_wdata  one-cycle memory write
//   word_count      words written in the current/last session
//   active          session in progress
//   err_timeout     sticky: a partial word was discarded
//   err_overflow    sticky: bytes arrived after MAX_WORDS words
//   checksum        (LOADER_CHECKSUM_EN only) sum of written words
//
// Optional feature macro: LOADER_CHECKSUM_EN.
module uart_prog_loader #(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned MAX_WORDS      = 65536,
  parameter bit          BIG_ENDIAN     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic                  active,
  output logic                  err_timeout,
  output logic                  err_overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [WORD_WIDTH-1:0] checksum
`endif
);

  localparam int unsigned BYTES = WORD_WIDTH / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(BYTES - 1);
  localparam logic [CNT_W-1:0]      MAX_C    = CNT_W'(MAX_WORDS);
  localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE} state_t;

  state_t                r_state, w_state_d;
  logic                  r_load_en_q;
  logic [IDX_W-1:0]      r_idx;
  logic [TO_W-1:0]       r_to_cnt;
  logic [WORD_WIDTH-1:0] r_asm;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_we, r_active, r_terr, r_oerr;

  logic                  w_start, w_full, w_take, w_done, w_drop, w_timeout, w_ovf;
  logic [IDX_W-1:0]      w_idx_cur;
  logic [WORD_WIDTH+7:0] w_cat;
  logic [WORD_WIDTH-1:0] w_asm_next;

  assign w_start   = load_en & ~r_load_en_q;
  // A session start treats the incoming byte as byte 0 of a fresh word.
  assign w_idx_cur = w_start ? '0 : r_idx;
  // The word leaving WRITE this cycle already counts towards the limit.
  assign w_full    = (r_count + CNT_W'(r_state == S_WRITE)) >= MAX_C;

  // Shift the new byte in at the end that makes the first byte land correctly.
  assign w_cat      = BIG_ENDIAN ? {r_asm, rx_byte} : {rx_byte, r_asm};
  assign w_asm_next = BIG_ENDIAN ? w_cat[WORD_WIDTH-1:0] : w_cat[WORD_WIDTH+7:8];

  // Next-state and byte-handling decisions.
  always_comb begin
    w_state_d = r_state;
    w_take    = 1'b0;
    w_drop    = 1'b0;
    w_timeout = 1'b0;
    w_ovf     = 1'b0;
    if (w_start) begin
      w_state_d = S_COLLECT;
      w_take    = rx_valid;
    end else if (r_state != S_IDLE) begin
      if (!load_en) begin
        w_state_d = S_IDLE;
        w_drop    = 1'b1;
      end else begin
        w_state_d = S_COLLECT;
        if (rx_valid) begin
          if (w_full) w_ovf  = 1'b1;
          else        w_take = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (r_state == S_COLLECT) &&
                     (r_idx != '0) && (r_to_cnt == TO_LAST)) begin
          w_timeout = 1'b1;
          w_drop    = 1'b1;
        end
      end
    end
    w_done = w_take && (w_idx_cur == LAST_IDX);
    if (w_done) w_state_d = S_WRITE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_d;
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_load_en_q <= 1'b0;
      r_idx       <= '0;
      r_to_cnt    <= '0;
      r_asm       <= '0;
      r_wdata     <= '0;
      r_addr      <= BASE_A;
      r_count     <= '0;
      r_we        <= 1'b0;
      r_active    <= 1'b0;
      r_terr      <= 1'b0;
      r_oerr      <= 1'b0;
    end else begin
      r_load_en_q <= load_en;
      r_we        <= (w_state_d == S_WRITE);
      r_active    <= (w_state_d != S_IDLE);
      if (r_state == S_WRITE) begin
        r_addr  <= r_addr + ADDR_WIDTH'(1);
        r_count <= r_count + CNT_W'(1);
      end
      if (w_start) begin
        r_addr  <= BASE_A;
        r_count <= '0;
        r_terr  <= 1'b0;
        r_oerr  <= 1'b0;
      end
      if (w_take) begin
        r_asm <= w_asm_next;
        r_idx <= w_done ? '0 : w_idx_cur + IDX_W'(1);
        if (w_done) r_wdata <= w_asm_next;
      end else if (w_drop || w_start) begin
        r_idx <= '0;
      end
      if (w_take || w_drop || w_start) r_to_cnt <= '0;
      else if ((r_state == S_COLLECT) && (r_idx != '0)) r_to_cnt <= r_to_cnt + TO_W'(1);
      if (w_timeout) r_terr <= 1'b1;
      if (w_ovf)     r_oerr <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] r_csum;

  // Running sum of written words, updated as each WRITE retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_csum <= '0;
    else if (w_start)              r_csum <= '0;
    else if (r_state == S_WRITE)   r_csum <= r_csum + r_wdata;
  end

  assign checksum = r_csum;
`endif

  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign word_count   = r_count[ADDR_WIDTH-1:0];
  assign active       = r_active;
  assign err_timeout  = r_terr;
  assign err_overflow = r_oerr;

endmodule
